dp_result_accumulator: RTL

- Downstream stage of the parallel int8 dot-product unit. Consumes its 17-bit signed partial sums, one per handshake.
- Accumulates cfg_len partial sums on top of a bias, then applies a rounding right-shift and saturates to int8.
- Presents one quantized result per job, with the raw accumulator alongside, on a valid/ready output.
- Sits between the dot-product array and the result write-back buffer.

---
 rtl/dp_result_accumulator_if.sv | 36 +++
 rtl/dp_result_accumulator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dp_result_accumulator_if.sv
// Handshake and configuration bundle between the dot-product array,
// dp_result_accumulator and the result write-back buffer.
// slave: accumulator side. master: producer/consumer (or bench) side.
interface dp_result_accumulator_if #(
    parameter int unsigned IN_W    = 17,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned SHIFT_W = 5
);
    // job control
    logic               start;
    logic [LEN_W-1:0]   cfg_len;
    logic [ACC_W-1:0]   cfg_bias;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               busy;
    // partial-sum stream
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    // result stream
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic [ACC_W-1:0]   out_acc;
    logic               out_ovf;

    modport slave (
        input  start, cfg_len, cfg_bias, cfg_shift, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_acc, out_ovf
    );

    modport master (
        output start, cfg_len, cfg_bias, cfg_shift, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, out_acc, out_ovf
    );
endinterface

// File: rtl/dp_result_accumulator.sv
// dp_result_accumulator: sums cfg_len signed partial sums onto a bias with
// saturation, then requantizes (round-half-up arithmetic shift) to int8.
// Optional macro DP_ACC_RELU_EN: negative quantized results are forced to 0.
module dp_result_accumulator #(
    parameter int unsigned IN_W    = 17,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    dp_result_accumulator_if.slave  bus
);

    localparam int unsigned EXT_W = ACC_W + 1;
    localparam int unsigned Q_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_ROUND,
        S_OUT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_acc_nxt;
    logic [LEN_W-1:0]     r_count;
    logic [LEN_W-1:0]     w_count_nxt;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     w_len_nxt;
    logic [SHIFT_W-1:0]   r_shift;
    logic [SHIFT_W-1:0]   w_shift_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic [Q_W-1:0]       r_out_data;
    logic [Q_W-1:0]       w_out_data_nxt;
    logic [ACC_W-1:0]     r_out_acc;
    logic [ACC_W-1:0]     w_out_acc_nxt;
    logic                 r_busy;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic                 w_in_hs;
    logic                 w_out_hs;
    logic signed [EXT_W-1:0] w_acc_ext;
    logic signed [EXT_W-1:0] w_in_ext;
    logic signed [EXT_W-1:0] w_sum;
    logic                 w_sat_hi;
    logic                 w_sat_lo;
    logic [ACC_W-1:0]     w_sum_sat;
    logic [EXT_W-1:0]     w_half;
    logic signed [EXT_W-1:0] w_rnd_sum;
    logic signed [EXT_W-1:0] w_rnd;
    logic                 w_q_pos_ovf;
    logic                 w_q_neg_ovf;
    logic [Q_W-1:0]       w_q;

    assign w_in_hs  = bus.in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & bus.out_ready;

    // Saturating accumulate evaluated one bit wider than the accumulator
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
    assign w_in_ext  = {{(EXT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign w_sum     = w_acc_ext + w_in_ext;
    assign w_sat_hi  = ~w_sum[EXT_W-1] &  w_sum[EXT_W-2];
    assign w_sat_lo  =  w_sum[EXT_W-1] & ~w_sum[EXT_W-2];
    assign w_sum_sat = w_sat_hi ? {1'b0, {(ACC_W-1){1'b1}}} :
                       w_sat_lo ? {1'b1, {(ACC_W-1){1'b0}}} :
                                  w_sum[ACC_W-1:0];

    // Round-half-up requantization and int8 clamp
    assign w_half      = (r_shift == '0) ? '0 : (EXT_W'(1) << (r_shift - SHIFT_W'(1)));
    assign w_rnd_sum   = w_acc_ext + $signed(w_half);
    assign w_rnd       = w_rnd_sum >>> r_shift;
    assign w_q_pos_ovf = ~w_rnd[EXT_W-1] &  (|w_rnd[EXT_W-2:Q_W-1]);
    assign w_q_neg_ovf =  w_rnd[EXT_W-1] & ~(&w_rnd[EXT_W-2:Q_W-1]);
`ifdef DP_ACC_RELU_EN
    assign w_q = w_rnd[EXT_W-1] ? '0 :
                 w_q_pos_ovf    ? Q_W'(8'h7F) :
                                  w_rnd[Q_W-1:0];
`else
    assign w_q = w_q_pos_ovf ? Q_W'(8'h7F) :
                 w_q_neg_ovf ? Q_W'(8'h80) :
                               w_rnd[Q_W-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_count_nxt    = r_count;
        w_len_nxt      = r_len;
        w_shift_nxt    = r_shift;
        w_ovf_nxt      = r_ovf;
        w_out_data_nxt = r_out_data;
        w_out_acc_nxt  = r_out_acc;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_len_nxt   = bus.cfg_len;
                    w_shift_nxt = bus.cfg_shift;
                    w_acc_nxt   = bus.cfg_bias;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (bus.cfg_len == '0) ? S_ROUND : S_ACC;
                end
            end
            S_ACC: begin
                if (w_in_hs) begin
                    w_acc_nxt   = w_sum_sat;
                    w_ovf_nxt   = r_ovf | w_sat_hi | w_sat_lo;
                    w_count_nxt = r_count + LEN_W'(1);
                    if (r_count == (r_len - LEN_W'(1))) begin
                        w_state_nxt = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                w_out_data_nxt = w_q;
                w_out_acc_nxt  = r_acc;
                w_state_nxt    = S_OUT;
            end
            S_OUT: begin
                if (w_out_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_ovf       <= 1'b0;
            r_out_data  <= '0;
            r_out_acc   <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_count     <= w_count_nxt;
            r_len       <= w_len_nxt;
            r_shift     <= w_shift_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_acc   <= w_out_acc_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_in_ready  <= (w_state_nxt == S_ACC);
            r_out_valid <= (w_state_nxt == S_OUT);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_acc   = r_out_acc;
    assign bus.out_ovf   = r_ovf;

endmodule
